// File: rtl/mem_writeback_unit.sv
// ---------------------------------------------------------------------------
// mem_writeback_unit
//
// Memory-access stage sitting between the EX/MEM pipeline register and the
// register file write port. Non-memory instructions pass their ALU result
// straight to the write port. Loads and stores are issued over a valid/ready
// data-memory handshake. Load data is aligned and sign/zero-extended, and
// store data is replicated across byte lanes with matching byte enables.
// While a memory access is outstanding, upstream stages are stalled.
//
// All write-port and memory-request outputs are registered. A result
// therefore appears one cycle after its instruction completes.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_*               EX/MEM register contents (valid, op, address, data, dest)
//   mem_req/we/addr/wdata/byteEn
//                      registered data-memory request, held stable until mem_ready
//   mem_ready/rdata    memory completion and read word
//   wb_writeEnable/addr/result
//                      registered register-file write port
//   stall              combinational hold for EX/MEM and earlier stages
//   misaligned         one-cycle pulse after a misaligned access is dropped
// ---------------------------------------------------------------------------
module mem_writeback_unit #(
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [3:0]            in_memOp,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [31:0]           in_storeData,
  input  logic [31:0]           in_aluResult,
  input  logic [REG_ADDR_W-1:0] in_regDest,
  input  logic                  in_regWriteEnable,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_byteEn,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata,
  output logic                  wb_writeEnable,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [31:0]           wb_result,
  output logic                  stall,
  output logic                  misaligned
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e                  state_q;
  logic [3:0]              op_q;
  logic [1:0]              off_q;
  logic [REG_ADDR_W-1:0]   dest_q;
  logic                    rwe_q;

  logic                    mem_req_q, mem_we_q, wb_we_q, misaligned_q;
  logic [ADDR_W-1:0]       mem_addr_q;
  logic [31:0]             mem_wdata_q, wb_result_q;
  logic [3:0]              mem_be_q;
  logic [REG_ADDR_W-1:0]   wb_addr_q;

  // Decode of the incoming operation.
  logic is_load, is_store, is_half, is_word, addr_ok, issue;

  assign is_load  = (in_memOp >= OP_LB) && (in_memOp <= OP_LW);
  assign is_store = (in_memOp >= OP_SB) && (in_memOp <= OP_SW);
  assign is_half  = (in_memOp == OP_LH) || (in_memOp == OP_LHU) || (in_memOp == OP_SH);
  assign is_word  = (in_memOp == OP_LW) || (in_memOp == OP_SW);
  assign addr_ok  = !(is_half && in_addr[0]) && !(is_word && (in_addr[1:0] != 2'b00));
  assign issue    = (state_q == ST_IDLE) && in_valid && (is_load || is_store) && addr_ok;

  // Stall is combinational so upstream holds in the issue cycle itself, and
  // releases in the mem_ready cycle so the held instruction advances exactly
  // at the completing edge.
  assign stall = (state_q == ST_IDLE) ? issue : !mem_ready;

  // Store lane placement from the incoming op and byte offset.
  logic [31:0] st_wdata;
  logic [3:0]  st_be;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    st_wdata = '0;
    st_be    = 4'b1111;
    case (in_memOp)
      OP_SB: begin
        st_wdata = {4{in_storeData[7:0]}};
        st_be    = 4'b0001 << in_addr[1:0];
      end
      OP_SH: begin
        st_wdata = {2{in_storeData[15:0]}};
        st_be    = in_addr[1] ? 4'b1100 : 4'b0011;
      end
      OP_SW: st_wdata = in_storeData;
      default: ;
    endcase
  end

  // Load alignment uses the op and offset latched at issue time, since the
  // in_* inputs are not trusted while waiting.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
  assign ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_data = mem_rdata;
    case (op_q)
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'h0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'h0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  logic load_we;
  assign load_we = rwe_q && (dest_q != '0) && (op_q <= OP_LW);

  logic none_we;
  assign none_we = in_regWriteEnable && (in_regDest != '0);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: reset is synchronous; the latched op/offset/dest registers are
  // reset too since they are only a handful of flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      off_q        <= '0;
      dest_q       <= '0;
      rwe_q        <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      wb_we_q      <= 1'b0;
      wb_addr_q    <= '0;
      wb_result_q  <= '0;
      misaligned_q <= 1'b0;
    end else begin
      // Write port and pulse default to idle every cycle.
      wb_we_q      <= 1'b0;
      wb_addr_q    <= '0;
      wb_result_q  <= '0;
      misaligned_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          mem_req_q   <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          mem_be_q    <= '0;
          if (in_valid) begin
            if (issue) begin
              state_q     <= ST_WAIT;
              op_q        <= in_memOp;
              off_q       <= in_addr[1:0];
              dest_q      <= in_regDest;
              rwe_q       <= in_regWriteEnable;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store;
              mem_addr_q  <= {in_addr[ADDR_W-1:2], 2'b00};
              mem_wdata_q <= st_wdata;
              mem_be_q    <= st_be;
            end else if (is_load || is_store) begin
              misaligned_q <= 1'b1;
            end else begin
              // Ops 0 and 9-15 behave as plain ALU writebacks.
              wb_we_q     <= none_we;
              wb_addr_q   <= none_we ? in_regDest : '0;
              wb_result_q <= none_we ? in_aluResult : '0;
            end
          end
        end

        ST_WAIT: begin
          // Request fields hold their values until the memory completes.
          if (mem_ready) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            wb_we_q     <= load_we;
            wb_addr_q   <= load_we ? dest_q : '0;
            wb_result_q <= load_we ? ld_data : '0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_byteEn     = mem_be_q;
  assign wb_writeEnable = wb_we_q;
  assign wb_addr        = wb_addr_q;
  assign wb_result      = wb_result_q;
  assign misaligned     = misaligned_q;

endmodule

// File: doc/mem_writeback_unit.md
Name: mem_writeback_unit

Overview:
Memory-access stage that drives the register file's write port (writeEnable/writeAddr/writeResult) from the EX/MEM pipeline register. It passes ALU results through, performs loads and stores over a valid/ready data-memory handshake, and aligns or extends load data. It stalls upstream stages while a memory access is outstanding. All write-port outputs are registered, so results appear one cycle after the instruction completes.

Parameters:
ADDR_W, 32, byte address width
REG_ADDR_W, 5, register index width; register 0 is hard-wired zero

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  EX/MEM holds a live instruction
in_memOp  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE
in_addr  in  ADDR_W  effective byte address
in_storeData  in  32  store source value
in_aluResult  in  32  result for non-memory ops
in_regDest  in  REG_ADDR_W  destination register
in_regWriteEnable  in  1  instruction writes a register
mem_req  out  1  request valid
mem_we  out  1  1 = store
mem_addr  out  ADDR_W  word-aligned address {in_addr[ADDR_W-1:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_byteEn  out  4  byte lane enables, little-endian
mem_ready  in  1  memory accepts/completes request this cycle
mem_rdata  in  32  read word, valid when mem_ready
wb_writeEnable  out  1  register write strobe
wb_addr  out  REG_ADDR_W  register write index
wb_result  out  32  register write data
stall  out  1  hold EX/MEM and earlier stages
misaligned  out  1  one-cycle pulse on misaligned access

Behaviour:
- Reset: state IDLE; mem_req, mem_we, mem_byteEn, wb_writeEnable, misaligned = 0; mem_addr, mem_wdata, wb_addr, wb_result = 0.
- FSM has two states, IDLE and WAIT.
- IDLE, in_valid=0: next cycle wb_writeEnable=0, wb_addr=0, wb_result=0.
- IDLE, NONE op: next cycle wb_writeEnable = in_regWriteEnable && in_regDest!=0; wb_addr=in_regDest; wb_result=in_aluResult; stall=0.
- If wb_writeEnable=0, wb_addr and wb_result are 0.
- Alignment rule: halfword ops need in_addr[0]=0; word ops need in_addr[1:0]=0.
- IDLE, misaligned memory op: no memory request, stall=0; next cycle misaligned=1, wb_writeEnable=0.
- IDLE, aligned memory op:
  - stall=1 combinationally in the same cycle.
  - Latch op, byte offset, in_regDest and in_regWriteEnable; go to WAIT.
  - mem_req=1 from the next cycle.
- WAIT:
  - mem_req=1; mem_we, mem_addr, mem_wdata and mem_byteEn stay stable until mem_ready.
  - stall = !mem_ready.
  - in_* inputs are ignored (held by upstream).
  - wb_writeEnable=0 each cycle.
- WAIT with mem_ready=1:
  - Next cycle: state IDLE, mem_req=0.
  - Load: wb_writeEnable = latched enable && dest!=0; wb_result = aligned data.
  - Store: wb_writeEnable=0.
  - Because stall drops during the mem_ready cycle, upstream advances at that edge, so the held instruction is never re-issued.
- Load alignment, with o = offset:
  - LB/LBU select byte rdata[8o+7:8o], sign- or zero-extended.
  - LH/LHU select rdata[15:0] when o=0, rdata[31:16] when o=2, sign- or zero-extended.
  - LW passes the word through.
- Store lanes:
  - SB: wdata = byte replicated 4x, byteEn = 1<<o.
  - SH: wdata = halfword replicated 2x, byteEn = 0011 (o=0) or 1100 (o=2).
  - SW: wdata = storeData, byteEn = 1111.
- Loads drive mem_byteEn=1111, mem_we=0.
- Minimum memory-op latency: 1 issue cycle + 1 WAIT cycle; wb outputs valid on the cycle after mem_ready.
- rst during WAIT: abandon the request at the next edge (mem_req=0, all outputs reset). The memory side must tolerate a dropped request.
- mem_ready while IDLE is ignored.

Test Plan:
- ALU op: valid, NONE, aluResult=0x1234_5678, dest=5, we=1 -> next cycle wb_writeEnable=1, wb_addr=5, wb_result=0x12345678, stall never high.
- LB sign-extend: addr=0x103, mem_ready after 3 WAIT cycles with rdata=0x80FF_0000 -> stall high 4 cycles, mem_addr=0x100, then wb_result=0xFFFFFF80, dest written.
- LHU: addr=0x202, rdata=0xBEEF_1234 -> wb_result=0x0000BEEF; same with LH -> 0xFFFFBEEF.
- SB: addr=0x301, storeData=0xAABB_CCDD -> mem_we=1, mem_addr=0x300, mem_wdata=0xDDDDDDDD, mem_byteEn=0010, then wb_writeEnable=0.
- Misaligned LW at addr=0x402 -> mem_req stays 0, stall=0, misaligned=1 for exactly one cycle, no register write.
- Load to dest=0 completes with wb_writeEnable=0; separately, rst asserted in WAIT -> next cycle mem_req=0, state IDLE, all outputs 0.
